// File: rtl/wb_arb_pkg.sv
// Shared types for the round-robin Wishbone arbiter: FSM state encoding and
// watchdog counter sizing.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Watchdog counter width is $clog2(TIMEOUT+1); kept at least 1 bit so a
  // disabled watchdog (TIMEOUT=0) still yields a legal vector.
  function automatic int wdog_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of per-master request/response lanes and the shared slave-side bus.
// The arbiter binds the slave modport; requesters and the slave decode bind master.
interface wb_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int SEL_W = DATA_W / 8;

  // Handshake: a strobe is accepted in a cycle where cyc & stb are high and
  // stall is low; it completes in the cycle where ack or err is high. A master
  // holds cyc for its whole tenure and may issue several strobes within it.
  logic [N_MASTERS-1:0]        m_wb_cyc;
  logic [N_MASTERS-1:0]        m_wb_stb;
  logic [N_MASTERS-1:0]        m_wb_we;
  logic [N_MASTERS*ADDR_W-1:0] m_wb_adr;
  logic [N_MASTERS*DATA_W-1:0] m_wb_dat_o;
  logic [N_MASTERS*SEL_W-1:0]  m_wb_sel;
  logic [N_MASTERS-1:0]        m_wb_ack;
  logic [N_MASTERS-1:0]        m_wb_err;
  logic [N_MASTERS-1:0]        m_wb_stall;
  logic [DATA_W-1:0]           m_wb_dat_i;

  logic                        s_wb_cyc;
  logic                        s_wb_stb;
  logic                        s_wb_we;
  logic [ADDR_W-1:0]           s_wb_adr;
  logic [DATA_W-1:0]           s_wb_dat_o;
  logic [SEL_W-1:0]            s_wb_sel;
  logic                        s_wb_ack;
  logic                        s_wb_err;
  logic                        s_wb_stall;
  logic [DATA_W-1:0]           s_wb_dat_i;

  modport slave (
    input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_dat_o, m_wb_sel,
    output m_wb_ack, m_wb_err, m_wb_stall, m_wb_dat_i,
    output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_o, s_wb_sel,
    input  s_wb_ack, s_wb_err, s_wb_stall, s_wb_dat_i
  );

  modport master (
    output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_dat_o, m_wb_sel,
    input  m_wb_ack, m_wb_err, m_wb_stall, m_wb_dat_i,
    input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_o, s_wb_sel,
    output s_wb_ack, s_wb_err, s_wb_stall, s_wb_dat_i
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester found scanning from
// last+1 upward, wrapping modulo N.
module wb_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int               sum;
    logic [IDX_W-1:0] cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    cand  = '0;
    // k = N revisits 'last' itself, so the previous owner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      sum = int'(last) + k;
      if (sum >= N) sum = sum - N;
      cand = IDX_W'(sum);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: one owner per tenure, shared-bus mux,
// per-owner response routing and a watchdog that aborts unanswered strobes.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  wb_bus_arbiter_if.slave      bus,
  output logic [N_MASTERS-1:0] grant,
  output logic                 timeout_err,
  output arb_state_t           state_dbg
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = wdog_width(TIMEOUT);
  localparam bit WDOG_ON = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fire;
  logic                 owner_cyc;
  logic                 stb_waiting;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic [ADDR_W-1:0] adr_a [N_MASTERS];
  logic [DATA_W-1:0] dat_a [N_MASTERS];
  logic [SEL_W-1:0]  sel_a [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slice
    assign adr_a[i] = bus.m_wb_adr[i*ADDR_W +: ADDR_W];
    assign dat_a[i] = bus.m_wb_dat_o[i*DATA_W +: DATA_W];
    assign sel_a[i] = bus.m_wb_sel[i*SEL_W +: SEL_W];
  end

  wb_rr_pick #(.N(N_MASTERS), .IDX_W(IDX_W)) u_pick (
    .req   (bus.m_wb_cyc),
    .last  (last_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // last_q doubles as the owner index while OWNED/ABORT.
  assign owner_cyc   = bus.m_wb_cyc[last_q];
  assign stb_waiting = bus.m_wb_stb[last_q] && !bus.s_wb_ack && !bus.s_wb_err;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    cnt_d          = '0;
    fire           = 1'b0;
    bus.s_wb_cyc   = 1'b0;
    bus.s_wb_stb   = 1'b0;
    bus.s_wb_we    = 1'b0;
    bus.s_wb_adr   = '0;
    bus.s_wb_dat_o = '0;
    bus.s_wb_sel   = '0;
    bus.m_wb_ack   = '0;
    bus.m_wb_err   = '0;
    bus.m_wb_stall = '1;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWNED;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      OWNED: begin
        bus.s_wb_cyc   = owner_cyc;
        bus.s_wb_stb   = bus.m_wb_stb[last_q];
        bus.s_wb_we    = bus.m_wb_we[last_q];
        bus.s_wb_adr   = adr_a[last_q];
        bus.s_wb_dat_o = dat_a[last_q];
        bus.s_wb_sel   = sel_a[last_q];
        fire           = WDOG_ON && owner_cyc && stb_waiting && (cnt_q == CNT_LAST);
        bus.m_wb_ack[last_q]   = bus.s_wb_ack;
        bus.m_wb_err[last_q]   = bus.s_wb_err | fire;
        bus.m_wb_stall[last_q] = bus.s_wb_stall;
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (fire) begin
          state_d = ABORT;
        end else if (WDOG_ON && stb_waiting) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ABORT: begin
        // Bus cyc/stb stay low so the hung slave sees the cycle end.
        bus.s_wb_we    = bus.m_wb_we[last_q];
        bus.s_wb_adr   = adr_a[last_q];
        bus.s_wb_dat_o = dat_a[last_q];
        bus.s_wb_sel   = sel_a[last_q];
        if (!owner_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.m_wb_dat_i = bus.s_wb_dat_i;
  assign grant          = grant_q;
  assign timeout_err    = fire;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an ownership-level model.
module tb_wb_bus_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 4;

  logic       clk;
  logic       rst_n = 1'b0;
  logic [N-1:0] grant;
  logic       timeout_err;
  arb_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership view: who holds the bus (-1 none), whether the tenure was
  // aborted, who won last, and how many unanswered strobe cycles in a row.
  int md_owner = -1, md_last = N - 1, md_waits = 0;
  bit md_abort = 1'b0;
  int nx_owner = -1, nx_last = N - 1, nx_waits = 0;
  bit nx_abort = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_owner = -1; md_last = N - 1; md_waits = 0; md_abort = 1'b0;
    end else begin
      md_owner = nx_owner; md_last = nx_last; md_waits = nx_waits; md_abort = nx_abort;
    end
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0]  e_grant, e_ack, e_err, e_stall;
    logic          e_scyc, e_sstb, e_swe, e_tout;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    bit            fire, waiting;
    int            ow, c;
    ow = md_owner;
    fire = 1'b0; waiting = 1'b0;
    e_grant = '0; e_ack = '0; e_err = '0; e_stall = '1;
    e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_tout = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (ow >= 0) begin
      e_grant = N'(1) << ow;
      e_swe   = bus.m_wb_we[ow];
      e_adr   = bus.m_wb_adr[ow*AW +: AW];
      e_dat   = bus.m_wb_dat_o[ow*DW +: DW];
      e_sel   = bus.m_wb_sel[ow*SW +: SW];
      if (!md_abort) begin
        waiting     = bus.m_wb_stb[ow] && !bus.s_wb_ack && !bus.s_wb_err;
        fire        = bus.m_wb_cyc[ow] && waiting && (md_waits + 1 == T);
        e_scyc      = bus.m_wb_cyc[ow];
        e_sstb      = bus.m_wb_stb[ow];
        e_ack[ow]   = bus.s_wb_ack;
        e_err[ow]   = bus.s_wb_err | fire;
        e_stall[ow] = bus.s_wb_stall;
        e_tout      = fire;
      end
    end
    check("grant",      grant,          e_grant);
    check("s_cyc",      bus.s_wb_cyc,   e_scyc);
    check("s_stb",      bus.s_wb_stb,   e_sstb);
    check("s_we",       bus.s_wb_we,    e_swe);
    check("s_adr",      bus.s_wb_adr,   e_adr);
    check("s_dat",      bus.s_wb_dat_o, e_dat);
    check("s_sel",      bus.s_wb_sel,   e_sel);
    check("m_ack",      bus.m_wb_ack,   e_ack);
    check("m_err",      bus.m_wb_err,   e_err);
    check("m_stall",    bus.m_wb_stall, e_stall);
    check("m_dat_i",    bus.m_wb_dat_i, bus.s_wb_dat_i);
    check("timeout",    timeout_err,    e_tout);

    nx_owner = md_owner; nx_last = md_last; nx_waits = 0; nx_abort = md_abort;
    if (ow < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (md_last + k) % N;
        if (nx_owner < 0 && bus.m_wb_cyc[c]) nx_owner = c;
      end
      if (nx_owner >= 0) begin
        nx_last = nx_owner; nx_abort = 1'b0;
      end
    end else if (!bus.m_wb_cyc[ow]) begin
      nx_owner = -1; nx_abort = 1'b0;
    end else if (!md_abort) begin
      if (fire) nx_abort = 1'b1;
      else if (waiting) nx_waits = md_waits + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    bus.m_wb_cyc[i] = cyc;
    bus.m_wb_stb[i] = stb;
    bus.m_wb_we[i]  = we;
    bus.m_wb_adr[i*AW +: AW]   = adr;
    bus.m_wb_dat_o[i*DW +: DW] = dat;
    bus.m_wb_sel[i*SW +: SW]   = sel;
  endtask

  task automatic clear_inputs();
    bus.m_wb_cyc = '0; bus.m_wb_stb = '0; bus.m_wb_we = '0;
    bus.m_wb_adr = '0; bus.m_wb_dat_o = '0; bus.m_wb_sel = '0;
    bus.s_wb_ack = 1'b0; bus.s_wb_err = 1'b0; bus.s_wb_stall = 1'b0;
    bus.s_wb_dat_i = 32'h1234_5678;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] seq [6];
  int ng;
  int hold [N];
  bit quiet;

  initial begin
    clear_inputs();
    // Reset values
    step(); step();
    sample();
    check("rst_grant", grant, 3'b000);
    check("rst_stall", bus.m_wb_stall, 3'b111);
    check("rst_scyc", bus.s_wb_cyc, 1'b0);
    check("rst_dat_i", bus.m_wb_dat_i, 32'h1234_5678);
    step();
    rst_n = 1'b1;

    // Single master write with ack one cycle after stb
    step(); set_m(0, 1, 1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    sample(); check("single_grant_t", grant, 3'b000);
    step(); sample();
    check("single_grant_t1", grant, 3'b001);
    check("single_adr", bus.s_wb_adr, 32'h10);
    check("single_dat", bus.s_wb_dat_o, 32'hDEAD_BEEF);
    step(); bus.s_wb_ack = 1'b1;
    sample(); check("single_ack", bus.m_wb_ack, 3'b001);
    step(); set_m(0, 0, 0, 0, 0, 0, 0); bus.s_wb_ack = 1'b0;
    sample(); check("single_grant_drop", grant, 3'b001);
    step(); sample(); check("single_grant_idle", grant, 3'b000);

    // Contention: m0 and m1 together, m0 first, m1 two cycles after release
    do_reset();
    step(); set_m(0, 1, 1, 0, 32'h20, 0, 4'hF); set_m(1, 1, 1, 0, 32'h30, 0, 4'hF);
    step(); sample();
    check("cont_grant0", grant, 3'b001);
    check("cont_stall", bus.m_wb_stall, 3'b110);
    step(); bus.s_wb_ack = 1'b1;
    sample(); check("cont_ack", bus.m_wb_ack, 3'b001);
    step(); set_m(0, 0, 0, 0, 0, 0, 0); bus.s_wb_ack = 1'b0;
    sample(); check("cont_hold", grant, 3'b001);
    step(); sample(); check("cont_dead", grant, 3'b000);
    step(); sample();
    check("cont_grant1", grant, 3'b010);
    check("cont_adr1", bus.s_wb_adr, 32'h30);
    step(); set_m(1, 0, 0, 0, 0, 0, 0);
    step();

    // Fairness: two continuous requesters alternate
    do_reset();
    ng = 0;
    for (int i = 0; i < 6; i++) seq[i] = '0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      step();
      for (int i = 0; i < 2; i++) bus.m_wb_cyc[i] = !grant[i];
      sample();
      if (grant != '0) begin
        seq[ng] = grant;
        ng++;
      end
    end
    check("fair_count", ng, 6);
    for (int i = 0; i < 6; i++) check("fair_seq", seq[i], (i % 2 == 0) ? 3'b001 : 3'b010);
    clear_inputs();
    step(); step();

    // Burst hold: m1 keeps ownership over three strobes while m0 waits
    do_reset();
    step(); set_m(1, 1, 0, 0, 0, 0, 4'hF);
    step(); bus.m_wb_cyc[0] = 1'b1; set_m(1, 1, 1, 1, 32'h40, 32'h1, 4'hF); bus.s_wb_ack = 1'b1;
    sample(); check("burst_grant", grant, 3'b010); check("burst_stall", bus.m_wb_stall, 3'b101);
    for (int b = 1; b < 3; b++) begin
      step(); set_m(1, 1, 1, 1, 32'h40 + 4 * b, b, 4'hF);
      sample(); check("burst_grant", grant, 3'b010); check("burst_ack", bus.m_wb_ack, 3'b010);
    end
    step(); bus.m_wb_stb[1] = 1'b0; bus.s_wb_ack = 1'b0;
    sample(); check("burst_gap", grant, 3'b010);
    step(); bus.m_wb_cyc[1] = 1'b0;
    sample(); check("burst_drop", grant, 3'b010);
    step(); sample(); check("burst_dead", grant, 3'b000);
    step(); sample(); check("burst_m0", grant, 3'b001);
    clear_inputs();
    step(); step();

    // Watchdog: slave never answers
    do_reset();
    step(); set_m(0, 1, 1, 0, 32'h50, 0, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      step(); sample(); check("wd_quiet", timeout_err, 1'b0);
    end
    step(); sample();
    check("wd_fire", timeout_err, 1'b1);
    check("wd_err", bus.m_wb_err, 3'b001);
    step(); sample();
    check("wd_after", timeout_err, 1'b0);
    check("wd_scyc", bus.s_wb_cyc, 1'b0);
    check("wd_grant", grant, 3'b001);
    check("wd_stall", bus.m_wb_stall, 3'b111);
    step(); set_m(0, 0, 0, 0, 0, 0, 0);
    sample(); check("wd_hold", grant, 3'b001);
    step(); sample(); check("wd_idle", grant, 3'b000);

    // Reset mid-transfer
    do_reset();
    step(); set_m(0, 1, 1, 0, 32'h60, 0, 4'hF); bus.m_wb_cyc[1] = 1'b1; bus.s_wb_ack = 1'b1;
    step(); sample(); check("rmid_grant", grant, 3'b001);
    step(); rst_n = 1'b0; #1;
    check("rmid_async_grant", grant, 3'b000);
    check("rmid_async_scyc", bus.s_wb_cyc, 1'b0);
    check("rmid_async_ack", bus.m_wb_ack, 3'b000);
    step(); rst_n = 1'b1;
    step(); sample(); check("rmid_regrant", grant, 3'b001);
    clear_inputs();
    step(); step(); step();

    // Randomized traffic
    for (int i = 0; i < N; i++) hold[i] = 0;
    quiet = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.m_wb_cyc[i]) begin
          if (grant[i]) begin
            if (hold[i] == 0) bus.m_wb_cyc[i] = 1'b0;
            else hold[i]--;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          bus.m_wb_cyc[i] = 1'b1;
          hold[i] = $urandom_range(0, 7);
        end
        bus.m_wb_stb[i] = bus.m_wb_cyc[i] && ($urandom_range(0, 3) != 0);
        bus.m_wb_we[i]  = 1'($urandom_range(0, 1));
        bus.m_wb_adr[i*AW +: AW]   = $urandom;
        bus.m_wb_dat_o[i*DW +: DW] = $urandom;
        bus.m_wb_sel[i*SW +: SW]   = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) quiet = !quiet;
      bus.s_wb_ack   = !quiet && ($urandom_range(0, 9) < 4);
      bus.s_wb_err   = !quiet && !bus.s_wb_ack && ($urandom_range(0, 9) == 0);
      bus.s_wb_stall = ($urandom_range(0, 3) == 0);
      bus.s_wb_dat_i = $urandom;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    clear_inputs();
    step(); step(); step();
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
